// File: rtl/bus_arbiter.sv
// N-to-1 round-robin request arbiter with an in-order ID FIFO that steers
// each memory response back to the requester that issued it.
module bus_arbiter #(
   parameter int unsigned NumReq         = 2,
   parameter int unsigned AddrWidth      = 64,
   parameter int unsigned DataWidth      = 64,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [NumReq-1:0]                req_valid_i,
   output logic [NumReq-1:0]                req_ready_o,
   input  logic [NumReq*AddrWidth-1:0]      req_addr_i,
   input  logic [NumReq*DataWidth-1:0]      req_wdata_i,
   input  logic [NumReq*DataWidth/8-1:0]    req_wmask_i,
   output logic [DataWidth-1:0]             req_rdata_o,
   output logic [NumReq-1:0]                req_rvalid_o,
   output logic                             mem_valid_o,
   input  logic                             mem_ready_i,
   output logic [AddrWidth-1:0]             mem_addr_o,
   output logic [DataWidth-1:0]             mem_wdata_o,
   output logic [DataWidth/8-1:0]           mem_wmask_o,
   input  logic [DataWidth-1:0]             mem_rdata_i,
   input  logic                             mem_rvalid_i,
   output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
   output logic                             err_o
);

   localparam int unsigned PtrW  = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int unsigned FifoW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
   localparam int unsigned MaskW = DataWidth / 8;

   logic [PtrW-1:0]  r_ptr;
   logic [PtrW-1:0]  r_fifo [MaxOutstanding];
   logic [FifoW-1:0] r_wr;
   logic [FifoW-1:0] r_rd;
   logic [CntW-1:0]  r_cnt;
   logic             r_err;

   logic [PtrW-1:0]  w_grant;
   logic [PtrW-1:0]  w_idx;
   logic [PtrW-1:0]  w_head;
   logic             w_any;
   logic             w_full;
   logic             w_empty;
   logic             w_hs;
   logic             w_pop;

   assign w_full  = (r_cnt == CntW'(MaxOutstanding));
   assign w_empty = (r_cnt == '0);
   assign w_head  = r_fifo[r_rd];

   // Rotating priority search starting at the round-robin pointer.
   always_comb begin
      w_grant = '0;
      w_idx   = '0;
      w_any   = 1'b0;
      for (int i = 0; i < int'(NumReq); i++) begin
         w_idx = PtrW'((int'(r_ptr) + i) % int'(NumReq));
         if (!w_any && req_valid_i[w_idx]) begin
            w_any   = 1'b1;
            w_grant = w_idx;
         end
      end
   end

   assign mem_valid_o = w_any && !w_full;
   assign w_hs        = mem_valid_o && mem_ready_i;
   assign w_pop       = mem_rvalid_i && !w_empty;

   always_comb begin
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      mem_wmask_o  = '0;
      req_ready_o  = '0;
      req_rvalid_o = '0;
      for (int i = 0; i < int'(NumReq); i++) begin
         if (w_any && (w_grant == PtrW'(i))) begin
            mem_addr_o  = req_addr_i[i*AddrWidth +: AddrWidth];
            mem_wdata_o = req_wdata_i[i*DataWidth +: DataWidth];
            mem_wmask_o = req_wmask_i[i*MaskW +: MaskW];
         end
         req_ready_o[i]  = w_hs && (w_grant == PtrW'(i));
         req_rvalid_o[i] = w_pop && (w_head == PtrW'(i));
      end
   end

   assign req_rdata_o   = mem_rdata_i;
   assign outstanding_o = r_cnt;
   assign err_o         = r_err;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr <= '0;
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_hs) begin
            r_fifo[r_wr] <= w_grant;
            r_wr  <= (r_wr == FifoW'(MaxOutstanding - 1)) ? '0 : r_wr + 1'b1;
            r_ptr <= (w_grant == PtrW'(NumReq - 1)) ? '0 : w_grant + 1'b1;
         end
         if (w_pop) begin
            r_rd <= (r_rd == FifoW'(MaxOutstanding - 1)) ? '0 : r_rd + 1'b1;
         end
         if (w_hs && !w_pop) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (!w_hs && w_pop) begin
            r_cnt <= r_cnt - 1'b1;
         end
         // A response with nothing outstanding is a responder protocol violation.
         if (mem_rvalid_i && w_empty) begin
            r_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed, table-driven bench for bus_arbiter (NumReq=2, MaxOutstanding=4).
module tb_bus_arbiter;

   localparam int unsigned NumReq = 2;
   localparam int unsigned AW     = 64;
   localparam int unsigned DW     = 64;
   localparam int unsigned MO     = 4;
   localparam logic [63:0] KData  = 64'hA5A5_5A5A_F00F_0FF0;
   localparam logic [7:0]  KMask  = 8'h3C;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NumReq-1:0]     req_valid;
   logic [NumReq-1:0]     req_ready;
   logic [NumReq*AW-1:0]  req_addr;
   logic [NumReq*DW-1:0]  req_wdata;
   logic [NumReq*DW/8-1:0] req_wmask;
   logic [DW-1:0]         req_rdata;
   logic [NumReq-1:0]     req_rvalid;
   logic                  mem_valid;
   logic                  mem_ready;
   logic [AW-1:0]         mem_addr;
   logic [DW-1:0]         mem_wdata;
   logic [DW/8-1:0]       mem_wmask;
   logic [DW-1:0]         mem_rdata;
   logic                  mem_rvalid;
   logic [2:0]            outstanding;
   logic                  err;

   int checks = 0;
   int errors = 0;

   bus_arbiter #(
      .NumReq(NumReq), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
      .req_rdata_o(req_rdata), .req_rvalid_o(req_rvalid),
      .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
      .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid),
      .outstanding_o(outstanding), .err_o(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  v;
      logic [63:0] a0;
      logic [63:0] a1;
      logic        mrdy;
      logic        mrv;
      logic [63:0] mrdata;
      logic [1:0]  e_rdy;
      logic        e_mv;
      logic [63:0] e_maddr;
      logic [1:0]  e_rvo;
      logic [63:0] e_rdata;
      logic [2:0]  e_out;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [1:0] v, input logic [63:0] a0, input logic [63:0] a1,
                      input logic mrdy, input logic mrv, input logic [63:0] mrdata,
                      input logic [1:0] e_rdy, input logic e_mv, input logic [63:0] e_maddr,
                      input logic [1:0] e_rvo, input logic [63:0] e_rdata,
                      input logic [2:0] e_out, input logic e_err);
      vec_t r;
      r.v = v; r.a0 = a0; r.a1 = a1; r.mrdy = mrdy; r.mrv = mrv; r.mrdata = mrdata;
      r.e_rdy = e_rdy; r.e_mv = e_mv; r.e_maddr = e_maddr; r.e_rvo = e_rvo;
      r.e_rdata = e_rdata; r.e_out = e_out; r.e_err = e_err;
      vecs.push_back(r);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [63:0] a0, input logic [63:0] a1,
                        input logic mrdy, input logic mrv, input logic [63:0] mrdata);
      req_valid  = v;
      req_addr   = {a1, a0};
      req_wdata  = {a1 ^ KData, a0 ^ KData};
      req_wmask  = {a1[7:0] ^ KMask, a0[7:0] ^ KMask};
      mem_ready  = mrdy;
      mem_rvalid = mrv;
      mem_rdata  = mrdata;
   endtask

   initial begin
      // Single requester 1, response two cycles later.
      add(2'b10, 64'h0, 64'h1000, 1, 0, 64'h0,   2'b10, 1, 64'h1000, 2'b00, 64'h0, 3'd0, 0);
      add(2'b00, 64'h0, 64'h0,    1, 0, 64'h0,   2'b00, 0, 64'h0,    2'b00, 64'h0, 3'd1, 0);
      add(2'b00, 64'h0, 64'h0,    1, 1, 64'hDEAD, 2'b00, 0, 64'h0,   2'b10, 64'hDEAD, 3'd1, 0);
      add(2'b00, 64'h0, 64'h0,    1, 0, 64'h0,   2'b00, 0, 64'h0,    2'b00, 64'h0, 3'd0, 0);
      // Fairness with latency-1 responder.
      add(2'b11, 64'h100, 64'h200, 1, 0, 64'h0,  2'b01, 1, 64'h100, 2'b00, 64'h0, 3'd1 - 3'd1, 0);
      add(2'b11, 64'h100, 64'h200, 1, 1, 64'hA0, 2'b10, 1, 64'h200, 2'b01, 64'hA0, 3'd1, 0);
      add(2'b11, 64'h100, 64'h200, 1, 1, 64'hA1, 2'b01, 1, 64'h100, 2'b10, 64'hA1, 3'd1, 0);
      add(2'b11, 64'h100, 64'h200, 1, 1, 64'hA2, 2'b10, 1, 64'h200, 2'b01, 64'hA2, 3'd1, 0);
      add(2'b00, 64'h100, 64'h200, 1, 1, 64'hA3, 2'b00, 0, 64'h0,   2'b10, 64'hA3, 3'd1, 0);
      // Backpressure: grant to req 0 holds for 3 stalled cycles.
      add(2'b11, 64'h300, 64'h400, 0, 0, 64'h0,  2'b00, 1, 64'h300, 2'b00, 64'h0, 3'd0, 0);
      add(2'b11, 64'h300, 64'h400, 0, 0, 64'h0,  2'b00, 1, 64'h300, 2'b00, 64'h0, 3'd0, 0);
      add(2'b11, 64'h300, 64'h400, 0, 0, 64'h0,  2'b00, 1, 64'h300, 2'b00, 64'h0, 3'd0, 0);
      add(2'b11, 64'h300, 64'h400, 1, 0, 64'h0,  2'b01, 1, 64'h300, 2'b00, 64'h0, 3'd0, 0);
      add(2'b11, 64'h300, 64'h400, 1, 0, 64'h0,  2'b10, 1, 64'h400, 2'b00, 64'h0, 3'd1, 0);
      add(2'b00, 64'h0, 64'h0,     1, 1, 64'hB0, 2'b00, 0, 64'h0,   2'b01, 64'hB0, 3'd2, 0);
      add(2'b00, 64'h0, 64'h0,     1, 1, 64'hB1, 2'b00, 0, 64'h0,   2'b10, 64'hB1, 3'd1, 0);
      add(2'b00, 64'h0, 64'h0,     1, 0, 64'h0,  2'b00, 0, 64'h0,   2'b00, 64'h0, 3'd0, 0);
      // Full: 4 accepted, 5th blocked until a response frees a slot.
      add(2'b01, 64'h500, 64'h0, 1, 0, 64'h0,    2'b01, 1, 64'h500, 2'b00, 64'h0, 3'd0, 0);
      add(2'b01, 64'h500, 64'h0, 1, 0, 64'h0,    2'b01, 1, 64'h500, 2'b00, 64'h0, 3'd1, 0);
      add(2'b01, 64'h500, 64'h0, 1, 0, 64'h0,    2'b01, 1, 64'h500, 2'b00, 64'h0, 3'd2, 0);
      add(2'b01, 64'h500, 64'h0, 1, 0, 64'h0,    2'b01, 1, 64'h500, 2'b00, 64'h0, 3'd3, 0);
      add(2'b01, 64'h500, 64'h0, 1, 0, 64'h0,    2'b00, 0, 64'h500, 2'b00, 64'h0, 3'd4, 0);
      add(2'b01, 64'h500, 64'h0, 1, 1, 64'hC0,   2'b00, 0, 64'h500, 2'b01, 64'hC0, 3'd4, 0);
      add(2'b01, 64'h500, 64'h0, 1, 0, 64'h0,    2'b01, 1, 64'h500, 2'b00, 64'h0, 3'd3, 0);
      add(2'b00, 64'h0, 64'h0,   1, 1, 64'hC1,   2'b00, 0, 64'h0,   2'b01, 64'hC1, 3'd4, 0);
      add(2'b00, 64'h0, 64'h0,   1, 1, 64'hC2,   2'b00, 0, 64'h0,   2'b01, 64'hC2, 3'd3, 0);
      add(2'b00, 64'h0, 64'h0,   1, 1, 64'hC3,   2'b00, 0, 64'h0,   2'b01, 64'hC3, 3'd2, 0);
      add(2'b00, 64'h0, 64'h0,   1, 1, 64'hC4,   2'b00, 0, 64'h0,   2'b01, 64'hC4, 3'd1, 0);
      add(2'b00, 64'h0, 64'h0,   1, 0, 64'h0,    2'b00, 0, 64'h0,   2'b00, 64'h0, 3'd0, 0);
      // Ordering: req0, req1, req0 then responses D0..D2.
      add(2'b01, 64'h10, 64'h0,  1, 0, 64'h0,    2'b01, 1, 64'h10,  2'b00, 64'h0, 3'd0, 0);
      add(2'b10, 64'h0, 64'h20,  1, 0, 64'h0,    2'b10, 1, 64'h20,  2'b00, 64'h0, 3'd1, 0);
      add(2'b01, 64'h30, 64'h0,  1, 0, 64'h0,    2'b01, 1, 64'h30,  2'b00, 64'h0, 3'd2, 0);
      add(2'b00, 64'h0, 64'h0,   1, 1, 64'hD0,   2'b00, 0, 64'h0,   2'b01, 64'hD0, 3'd3, 0);
      add(2'b00, 64'h0, 64'h0,   1, 1, 64'hD1,   2'b00, 0, 64'h0,   2'b10, 64'hD1, 3'd2, 0);
      add(2'b00, 64'h0, 64'h0,   1, 1, 64'hD2,   2'b00, 0, 64'h0,   2'b01, 64'hD2, 3'd1, 0);
      add(2'b00, 64'h0, 64'h0,   1, 0, 64'h0,    2'b00, 0, 64'h0,   2'b00, 64'h0, 3'd0, 0);
      // Stray response with empty FIFO sets a sticky error.
      add(2'b00, 64'h0, 64'h0,   1, 1, 64'h55,   2'b00, 0, 64'h0,   2'b00, 64'h0, 3'd0, 0);
      add(2'b00, 64'h0, 64'h0,   1, 0, 64'h0,    2'b00, 0, 64'h0,   2'b00, 64'h0, 3'd0, 1);
      add(2'b00, 64'h0, 64'h0,   1, 0, 64'h0,    2'b00, 0, 64'h0,   2'b00, 64'h0, 3'd0, 1);

      // Reset state.
      rst = 1'b1;
      drive(2'b00, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_outstanding", 64'(outstanding), 64'd0);
      chk("reset_err", 64'(err), 64'd0);
      chk("reset_mem_valid", 64'(mem_valid), 64'd0);
      chk("reset_rvalid", 64'(req_rvalid), 64'd0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].v, vecs[i].a0, vecs[i].a1, vecs[i].mrdy, vecs[i].mrv, vecs[i].mrdata);
         #1;
         chk($sformatf("row%0d_ready", i), 64'(req_ready), 64'(vecs[i].e_rdy));
         chk($sformatf("row%0d_mem_valid", i), 64'(mem_valid), 64'(vecs[i].e_mv));
         chk($sformatf("row%0d_mem_addr", i), mem_addr, vecs[i].e_maddr);
         chk($sformatf("row%0d_mem_wdata", i), mem_wdata,
             (vecs[i].e_maddr == 64'h0) ? 64'h0 : (vecs[i].e_maddr ^ KData));
         chk($sformatf("row%0d_mem_wmask", i), 64'(mem_wmask),
             (vecs[i].e_maddr == 64'h0) ? 64'h0 : 64'(vecs[i].e_maddr[7:0] ^ KMask));
         chk($sformatf("row%0d_rvalid", i), 64'(req_rvalid), 64'(vecs[i].e_rvo));
         if (vecs[i].e_rvo != 2'b00) begin
            chk($sformatf("row%0d_rdata", i), req_rdata, vecs[i].e_rdata);
         end
         chk($sformatf("row%0d_outstanding", i), 64'(outstanding), 64'(vecs[i].e_out));
         chk($sformatf("row%0d_err", i), 64'(err), 64'(vecs[i].e_err));
      end

      // Reset mid-operation: two outstanding, pointer left at 1, sticky error set.
      @(negedge clk);
      drive(2'b11, 64'h700, 64'h800, 1'b1, 1'b0, 64'h0);
      #1;
      chk("pre_rst_grant1", 64'(req_ready), 64'(2'b10));
      @(negedge clk);
      #1;
      chk("pre_rst_grant0", 64'(req_ready), 64'(2'b01));
      @(negedge clk);
      drive(2'b00, 64'h700, 64'h800, 1'b1, 1'b0, 64'h0);
      #1;
      chk("pre_rst_outstanding", 64'(outstanding), 64'd2);
      chk("pre_rst_err", 64'(err), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(2'b11, 64'h700, 64'h800, 1'b1, 1'b0, 64'h0);
      #1;
      chk("post_rst_outstanding", 64'(outstanding), 64'd0);
      chk("post_rst_err", 64'(err), 64'd0);
      chk("post_rst_ptr_grant0", 64'(req_ready), 64'(2'b01));
      chk("post_rst_mem_addr", mem_addr, 64'h700);
      // Old responder answers a request lost in reset; the new request keeps it in the FIFO.
      @(negedge clk);
      drive(2'b00, 64'h0, 64'h0, 1'b1, 1'b1, 64'hE0);
      #1;
      chk("post_rst_rvalid_routed", 64'(req_rvalid), 64'(2'b01));
      @(negedge clk);
      drive(2'b00, 64'h0, 64'h0, 1'b1, 1'b1, 64'hE1);
      #1;
      chk("post_rst_stray_rvalid", 64'(req_rvalid), 64'd0);
      @(negedge clk);
      drive(2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0);
      #1;
      chk("post_rst_err_set", 64'(err), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Parametrised N-to-1 arbiter for the core's valid/ready request bus with decoupled rvalid responses.
- Lets several requesters (e.g. fetch, LSU, debug) share one memory responder port.
- Round-robin grant on the request side; an in-order ID FIFO routes each rvalid/rdata back to the requester that issued the request.
- Sits between the requester ports of the core and a single memory/bus responder.

Parameters:
- NumReq, 2, number of requester ports (>=2).
- AddrWidth, 64, address width.
- DataWidth, 64, data width; mask width is DataWidth/8.
- MaxOutstanding, 4, maximum accepted-but-unanswered requests (power of 2, >=1).

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_i  input  1  synchronous active-high reset.
- req_valid_i  input  NumReq  per-requester request valid.
- req_ready_o  output  NumReq  per-requester request accepted.
- req_addr_i  input  NumReq*AddrWidth  packed addresses, requester i at slice i.
- req_wdata_i  input  NumReq*DataWidth  packed write data.
- req_wmask_i  input  NumReq*DataWidth/8  packed byte mask; all-zero means read.
- req_rdata_o  output  DataWidth  response data, broadcast to all requesters.
- req_rvalid_o  output  NumReq  one-hot response valid.
- mem_valid_o  output  1  downstream request valid.
- mem_ready_i  input  1  downstream accept.
- mem_addr_o  output  AddrWidth  granted address.
- mem_wdata_o  output  DataWidth  granted write data.
- mem_wmask_o  output  DataWidth/8  granted mask.
- mem_rdata_i  input  DataWidth  response data.
- mem_rvalid_i  input  1  response valid.
- outstanding_o  output  $clog2(MaxOutstanding+1)  current outstanding count.
- err_o  output  1  sticky protocol error.

Behaviour:
- Reset:
  - Round-robin pointer = 0; ID FIFO empty; outstanding_o = 0; err_o = 0.
  - req_rvalid_o = 0; mem_valid_o = 0 (no requests held during reset).
- Grant (combinational):
  - Search starts at the pointer and wraps; the first index with req_valid_i set wins.
  - mem_addr/wdata/wmask_o mux the granted slice; they are 0 when there is no grant.
- mem_valid_o = (any req_valid_i) && !full, where full = (outstanding == MaxOutstanding).
  - mem_valid_o never depends on mem_ready_i.
- req_ready_o[i] = mem_ready_i && mem_valid_o && (grant == i); at most one bit is set.
- Handshake (mem_valid_o && mem_ready_i):
  - Push granted ID into the FIFO.
  - Pointer <= (grant+1) mod NumReq.
  - Without a handshake the pointer holds, so a granted requester keeps its grant until accepted (no mid-request switch).
- Every accepted request, read or write, yields exactly one mem_rvalid_i, in order, at least 1 cycle after acceptance.
- Response routing (combinational):
  - When mem_rvalid_i is high and the FIFO is non-empty, req_rvalid_o[head] = 1, req_rdata_o = mem_rdata_i, and the head is popped at the clock edge.
  - Zero-cycle latency from mem to requester.
- Simultaneous push and pop: both occur; count is unchanged; pointers advance independently.
  - When full, a same-cycle pop does not allow a push in that cycle (full is evaluated from the registered count).
- mem_rvalid_i with the FIFO empty: err_o <= 1 (sticky until reset); req_rvalid_o stays 0; no pop.
- FIFO pointers wrap modulo MaxOutstanding.
- Reset mid-operation clears all pending IDs; any later rvalid from a non-reset responder flags err_o.

Test Plan:
- Single requester: NumReq=2, only req 1 valid, addr 0x1000, wmask 0, mem_ready=1 -> req_ready_o=2'b10 same cycle. Response rdata 0xDEAD two cycles later -> req_rvalid_o=2'b10, req_rdata_o=0xDEAD, outstanding 1->0.
- Fairness: both requesters valid continuously, mem_ready=1, responder latency 1 -> grants alternate 0,1,0,1 over 4 cycles; pointer 0 after reset gives requester 0 first.
- Backpressure hold: req 0 granted, mem_ready=0 for 3 cycles while req 1 also valid -> mem_addr_o stays req 0's address; no pointer change; accept on cycle 4, then req 1 granted.
- Full: MaxOutstanding=4, responder silent, 5 requests offered -> 4 accepted, outstanding_o=4, mem_valid_o=0. One rvalid -> push resumes the next cycle.
- Ordering: accept req0 (addr 0x10), req1 (0x20), req0 (0x30); responses D0,D1,D2 -> rvalid one-hot sequence 01,10,01 with matching data.
- Error/reset: rvalid with empty FIFO -> err_o=1 and stays 1. Assert rst_i for 1 cycle with 2 outstanding -> outstanding_o=0, err_o=0, pointer 0.
